// File: rtl/uart_load_controller.sv
// uart_load_controller
//   Hands instruction/data memory between the CPU and the UART loader.
//   RUN -> DRAIN (inject NO_OP bubbles) -> LOAD (UART owns the memory ports, IF retries)
//   -> RESTART (one-cycle pc_reset pulse) -> RUN.
//   Counts loaded words per memory. Aborts a stalled load after TIMEOUT_CYCLES idle cycles.
//
// Optional feature: define UART_LOAD_CHECKSUM_EN to add a load_checksum output,
//   which is the XOR of every counted uart_data word.
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   uart_req           level request to enter programming mode
//   uart_done          transfer complete (only looked at in LOAD)
//   uart_write_enable  UART word strobe
//   uart_addr          word address; MSB=1 selects data memory
//   uart_data          word value (feeds the optional checksum only)
//   uart_disable       1 = CPU owns memories, 0 = UART owns them
//   pc_reset           one-cycle pulse forcing PC to 0
//   hazard_control     IF-stage command NORMAL / NO_OP / RETRY
//   load_active        high in DRAIN and LOAD
//   load_error         sticky: the last load ended by timeout
//   imem_words         saturating count of instruction-memory words in the last/current load
//   dmem_words         saturating count of data-memory words in the last/current load
//   load_checksum      (UART_LOAD_CHECKSUM_EN only) XOR of the loaded words

`ifndef ROM_DEPTH
`define ROM_DEPTH 14
`endif
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef HAZD_CTL_WIDTH
`define HAZD_CTL_WIDTH 2
`endif
`ifndef HAZD_CTL_NORMAL
`define HAZD_CTL_NORMAL 2'd0
`endif
`ifndef HAZD_CTL_NO_OP
`define HAZD_CTL_NO_OP 2'd1
`endif
`ifndef HAZD_CTL_RETRY
`define HAZD_CTL_RETRY 2'd2
`endif

module uart_load_controller #(
    parameter int unsigned DRAIN_CYCLES   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 2**20,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       uart_req,
    input  logic                       uart_done,
    input  logic                       uart_write_enable,
    input  logic [`ROM_DEPTH:0]        uart_addr,
    input  logic [`ISA_WIDTH-1:0]      uart_data,
    output logic                       uart_disable,
    output logic                       pc_reset,
    output logic [`HAZD_CTL_WIDTH-1:0] hazard_control,
    output logic                       load_active,
    output logic                       load_error,
    output logic [CNT_WIDTH-1:0]       imem_words,
    output logic [CNT_WIDTH-1:0]       dmem_words
`ifdef UART_LOAD_CHECKSUM_EN
    ,
    output logic [`ISA_WIDTH-1:0]      load_checksum
`endif
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned IW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {RUN, DRAIN, LOAD, RESTART} state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          drain_q, drain_d;
    logic [IW-1:0]          idle_q, idle_d;
    logic [CNT_WIDTH-1:0]   imem_q, imem_d, dmem_q, dmem_d;
    logic                   err_q, err_d;
    logic [`ISA_WIDTH-1:0]  cks_q, cks_d;

    logic                       uart_disable_q, pc_reset_q, load_active_q;
    logic [`HAZD_CTL_WIDTH-1:0] hazard_q;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        idle_d  = idle_q;
        imem_d  = imem_q;
        dmem_d  = dmem_q;
        err_d   = err_q;
        cks_d   = cks_q;
        case (state_q)
            RUN: begin
                if (uart_req) begin
                    state_d = DRAIN;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = LOAD;
                    imem_d  = '0;
                    dmem_d  = '0;
                    err_d   = 1'b0;
                    idle_d  = '0;
                    cks_d   = '0;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            LOAD: begin
                if (uart_write_enable) begin
                    if (uart_addr[`ROM_DEPTH]) begin
                        dmem_d = (dmem_q == '1) ? dmem_q : dmem_q + 1'b1;
                    end else begin
                        imem_d = (imem_q == '1) ? imem_q : imem_q + 1'b1;
                    end
                    cks_d  = cks_q ^ uart_data;
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
                // The timeout looks at the registered idle count, so a write in
                // the final idle cycle is still counted before the abort.
                if (uart_done) begin
                    state_d = RESTART;
                end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = RESTART;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            drain_q        <= '0;
            idle_q         <= '0;
            imem_q         <= '0;
            dmem_q         <= '0;
            err_q          <= 1'b0;
            cks_q          <= '0;
            uart_disable_q <= 1'b1;
            pc_reset_q     <= 1'b0;
            load_active_q  <= 1'b0;
            hazard_q       <= `HAZD_CTL_NORMAL;
        end else begin
            state_q        <= state_d;
            drain_q        <= drain_d;
            idle_q         <= idle_d;
            imem_q         <= imem_d;
            dmem_q         <= dmem_d;
            err_q          <= err_d;
            cks_q          <= cks_d;
            // Outputs are registered copies of the decode of the state being entered.
            uart_disable_q <= (state_d != LOAD);
            pc_reset_q     <= (state_d == RESTART);
            load_active_q  <= (state_d == DRAIN) || (state_d == LOAD);
            hazard_q       <= (state_d == DRAIN) ? `HAZD_CTL_NO_OP :
                              (state_d == LOAD)  ? `HAZD_CTL_RETRY : `HAZD_CTL_NORMAL;
        end
    end

    assign uart_disable   = uart_disable_q;
    assign pc_reset       = pc_reset_q;
    assign load_active    = load_active_q;
    assign hazard_control = hazard_q;
    assign load_error     = err_q;
    assign imem_words     = imem_q;
    assign dmem_words     = dmem_q;

`ifdef UART_LOAD_CHECKSUM_EN
    assign load_checksum = cks_q;
    logic unused_inputs;
    assign unused_inputs = ^uart_addr[`ROM_DEPTH-1:0];
`else
    logic unused_inputs;
    assign unused_inputs = ^{uart_addr[`ROM_DEPTH-1:0], cks_q};
`endif

endmodule

// File: tb/tb_uart_load_controller.sv
`ifndef ROM_DEPTH
`define ROM_DEPTH 14
`endif
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef HAZD_CTL_WIDTH
`define HAZD_CTL_WIDTH 2
`endif

module tb_uart_load_controller;

    localparam logic [1:0] N  = 2'd0;
    localparam logic [1:0] NO = 2'd1;
    localparam logic [1:0] R  = 2'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_req = 1'b0, uart_done = 1'b0, uart_write_enable = 1'b0;
    logic [`ROM_DEPTH:0] uart_addr = '0;
    logic [`ISA_WIDTH-1:0] uart_data = '0;
    logic uart_disable, pc_reset, load_active, load_error;
    logic [`HAZD_CTL_WIDTH-1:0] hazard_control;
    logic [15:0] imem_words, dmem_words;
`ifdef UART_LOAD_CHECKSUM_EN
    logic [`ISA_WIDTH-1:0] load_checksum;
`endif

    uart_load_controller #(
        .DRAIN_CYCLES(5),
        .TIMEOUT_CYCLES(8),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_req(uart_req),
        .uart_done(uart_done),
        .uart_write_enable(uart_write_enable),
        .uart_addr(uart_addr),
        .uart_data(uart_data),
        .uart_disable(uart_disable),
        .pc_reset(pc_reset),
        .hazard_control(hazard_control),
        .load_active(load_active),
        .load_error(load_error),
        .imem_words(imem_words),
        .dmem_words(dmem_words)
`ifdef UART_LOAD_CHECKSUM_EN
        ,
        .load_checksum(load_checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  hz;
        logic        ud, pcr, la, err;
        logic [15:0] im, dm;
        logic [31:0] ck;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Expected counter/checksum values after the next edge, maintained by the script.
    logic [15:0] e_im = '0, e_dm = '0;
    logic        e_err = 1'b0;
    logic [31:0] e_ck = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic req, input logic done, input logic we,
                        input logic [`ROM_DEPTH:0] addr, input logic [31:0] data,
                        input logic [1:0] hz, input logic ud, input logic pcr, input logic la);
        exp_t e;
        @(negedge clk);
        uart_req = req;
        uart_done = done;
        uart_write_enable = we;
        uart_addr = addr;
        uart_data = data;
        e.hz = hz; e.ud = ud; e.pcr = pcr; e.la = la;
        e.err = e_err; e.im = e_im; e.dm = e_dm; e.ck = e_ck;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [1:0] hz, input logic ud, input logic pcr, input logic la);
        step(1'b0, 1'b0, 1'b0, '0, '0, hz, ud, pcr, la);
    endtask

    // Request pulse plus the remaining four bubble cycles.
    task automatic drain();
        step(1'b1, 1'b0, 1'b0, '0, '0, NO, 1'b1, 1'b0, 1'b1);
        repeat (4) idle(NO, 1'b1, 1'b0, 1'b1);
    endtask

    // Monitor: compares every queued expectation shortly after the active edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hazard_control", 32'(hazard_control), 32'(e.hz));
            check("uart_disable", 32'(uart_disable), 32'(e.ud));
            check("pc_reset", 32'(pc_reset), 32'(e.pcr));
            check("load_active", 32'(load_active), 32'(e.la));
            check("load_error", 32'(load_error), 32'(e.err));
            check("imem_words", 32'(imem_words), 32'(e.im));
            check("dmem_words", 32'(dmem_words), 32'(e.dm));
`ifdef UART_LOAD_CHECKSUM_EN
            check("load_checksum", 32'(load_checksum), e.ck);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset, then write strobes in RUN that must be ignored.
        repeat (10) idle(N, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 15'h0000, 32'hFFFF_FFFF, N, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 15'h4000, 32'hFFFF_FFFF, N, 1'b1, 1'b0, 1'b0);

        // Load 1: 3 imem + 2 dmem words, uart_req held high in LOAD (ignored), then done.
        drain();
        idle(R, 1'b0, 1'b0, 1'b1);
        e_im = 16'd1; step(1'b1, 1'b0, 1'b1, 15'h0000, '0, R, 1'b0, 1'b0, 1'b1);
        e_im = 16'd2; step(1'b1, 1'b0, 1'b1, 15'h0001, '0, R, 1'b0, 1'b0, 1'b1);
        e_im = 16'd3; step(1'b1, 1'b0, 1'b1, 15'h0002, '0, R, 1'b0, 1'b0, 1'b1);
        e_dm = 16'd1; step(1'b0, 1'b0, 1'b1, 15'h4000, '0, R, 1'b0, 1'b0, 1'b1);
        e_dm = 16'd2; step(1'b0, 1'b0, 1'b1, 15'h4001, '0, R, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, '0, N, 1'b1, 1'b1, 1'b0);
        idle(N, 1'b1, 1'b0, 1'b0);
        idle(N, 1'b1, 1'b0, 1'b0);

        // Load 2: no writes -> timeout after 8 LOAD cycles, load_error set and held.
        drain();
        e_im = '0; e_dm = '0;
        idle(R, 1'b0, 1'b0, 1'b1);
        repeat (7) idle(R, 1'b0, 1'b0, 1'b1);
        e_err = 1'b1;
        idle(N, 1'b1, 1'b1, 1'b0);
        idle(N, 1'b1, 1'b0, 1'b0);
        idle(N, 1'b1, 1'b0, 1'b0);

        // Load 3: error cleared on entry; write coinciding with done is counted;
        // uart_req held through RESTART re-enters DRAIN right after RUN.
        drain();
        e_err = 1'b0;
        idle(R, 1'b0, 1'b0, 1'b1);
        e_im = 16'd1; step(1'b0, 1'b0, 1'b1, 15'h0010, '0, R, 1'b0, 1'b0, 1'b1);
        e_im = 16'd2; step(1'b1, 1'b1, 1'b1, 15'h0011, '0, N, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, '0, N, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, '0, NO, 1'b1, 1'b0, 1'b1);
        repeat (4) idle(NO, 1'b1, 1'b0, 1'b1);

        // Load 4: checksum words, then asynchronous reset in the middle of LOAD.
        e_im = '0;
        idle(R, 1'b0, 1'b0, 1'b1);
        e_im = 16'd1; e_ck = 32'h1234_5678;
        step(1'b0, 1'b0, 1'b1, 15'h0000, 32'h1234_5678, R, 1'b0, 1'b0, 1'b1);
        e_dm = 16'd1; e_ck = 32'h1D3B_5977;
        step(1'b0, 1'b0, 1'b1, 15'h4000, 32'h0F0F_0F0F, R, 1'b0, 1'b0, 1'b1);
        idle(R, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        uart_write_enable = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_uart_disable", 32'(uart_disable), 32'd1);
        check("async_rst_load_active", 32'(load_active), 32'd0);
        check("async_rst_hazard", 32'(hazard_control), 32'(N));
        check("async_rst_imem", 32'(imem_words), 32'd0);
`ifdef UART_LOAD_CHECKSUM_EN
        check("async_rst_checksum", load_checksum, 32'd0);
`endif
        e_im = '0; e_dm = '0; e_ck = '0; e_err = 1'b0;
        idle(N, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(N, 1'b1, 1'b0, 1'b0);
        idle(N, 1'b1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
